swap_scheduler: RTL and testbench

- Controller for the up/down counter pair whose exchange is triggered by `swap` and `enable` both high.
- Drives `enable` and `swap` to sequence a programmed number of exchanges, each separated by a programmable count interval.
- An exchange can fire early when the up counter reaches a threshold.
- Sits beside the counter pair; monitors its outputs and reports progress with a `busy` flag and a `done` pulse.

---
 rtl/swap_scheduler_if.sv | 34 +++
 rtl/swap_scheduler.sv | 117 +++++++++++
 tb/tb_swap_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/swap_scheduler_if.sv
// Interface bundling the control, configuration, counter-monitor and status signals of
// swap_scheduler. clock and reset stay plain module ports.
//   master : the side that issues start/abort, programs the run and feeds the counter values
//   slave  : the scheduler itself (drives enable/swap to the counter pair and the status)
interface swap_scheduler_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP_W = 4,
    parameter int unsigned NS_W  = 4
);
    logic             start;
    logic             abort;
    logic [GAP_W-1:0] period;
    logic [NS_W-1:0]  n_swaps;
    logic             thresh_en;
    logic [WIDTH-1:0] thresh;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] down_val;
    logic             enable;
    logic             swap;
    logic             busy;
    logic             done;
    logic [NS_W-1:0]  swaps_done;
    logic [WIDTH-1:0] last_down;

    modport master (
        output start, abort, period, n_swaps, thresh_en, thresh, up_val, down_val,
        input  enable, swap, busy, done, swaps_done, last_down
    );

    modport slave (
        input  start, abort, period, n_swaps, thresh_en, thresh, up_val, down_val,
        output enable, swap, busy, done, swaps_done, last_down
    );
endinterface

// File: rtl/swap_scheduler.sv
// swap_scheduler: sequences a programmed number of exchanges on an up/down counter pair.
// Between exchanges the counters free-run for period+1 cycles, or fewer when the up counter
// hits the programmed threshold. Progress is reported via busy, a one-cycle done pulse,
// swaps_done and the down value captured at each exchange.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : swap_scheduler_if.slave (start/abort, run config, up/down values in;
//           enable/swap, busy/done, swaps_done/last_down out)
module swap_scheduler #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP_W = 4,
    parameter int unsigned NS_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    swap_scheduler_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StCount, StSwap, StFinish} state_e;

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] period_q, period_d;
    logic [NS_W-1:0]  n_q, n_d;
    logic             thresh_en_q, thresh_en_d;
    logic [WIDTH-1:0] thresh_q, thresh_d;
    logic [NS_W-1:0]  swaps_done_q, swaps_done_d;
    logic [WIDTH-1:0] last_down_q, last_down_d;
    logic [NS_W-1:0]  swaps_inc;

    assign swaps_inc = swaps_done_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        period_d     = period_q;
        n_d          = n_q;
        thresh_en_d  = thresh_en_q;
        thresh_d     = thresh_q;
        swaps_done_d = swaps_done_q;
        last_down_d  = last_down_q;

        // abort overrides every transition and freezes the progress registers
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        swaps_done_d = '0;
                        if (bus.n_swaps != '0) begin
                            period_d    = bus.period;
                            n_d         = bus.n_swaps;
                            thresh_en_d = bus.thresh_en;
                            thresh_d    = bus.thresh;
                            gap_d       = '0;
                            state_d     = StCount;
                        end else begin
                            state_d = StFinish;
                        end
                    end
                end
                StCount: begin
                    if ((gap_q == period_q) || (thresh_en_q && (bus.up_val == thresh_q))) begin
                        state_d = StSwap;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                StSwap: begin
                    swaps_done_d = swaps_inc;
                    last_down_d  = bus.down_val;
                    if (swaps_inc == n_q) begin
                        state_d = StFinish;
                    end else begin
                        gap_d   = '0;
                        state_d = StCount;
                    end
                end
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            gap_q        <= '0;
            period_q     <= '0;
            n_q          <= '0;
            thresh_en_q  <= 1'b0;
            thresh_q     <= '0;
            swaps_done_q <= '0;
            last_down_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            period_q     <= period_d;
            n_q          <= n_d;
            thresh_en_q  <= thresh_en_d;
            thresh_q     <= thresh_d;
            swaps_done_q <= swaps_done_d;
            last_down_q  <= last_down_d;
        end
    end

    // Outputs decode registered state only.
    assign bus.enable     = (state_q == StSwap);
    assign bus.swap       = (state_q == StSwap);
    assign bus.busy       = (state_q == StCount) || (state_q == StSwap);
    assign bus.done       = (state_q == StFinish);
    assign bus.swaps_done = swaps_done_q;
    assign bus.last_down  = last_down_q;

endmodule

// File: tb/tb_swap_scheduler.sv
// Scoreboard bench for swap_scheduler: stimulus pushes expected swap/done events (cycle,
// count, captured down value); a monitor pops and compares whenever swap or done is seen.
module tb_swap_scheduler;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int at;
        int sd;
        int ld;
    } ev_t;

    ev_t swap_q[$];
    ev_t done_q[$];

    swap_scheduler_if #(.WIDTH(4), .GAP_W(4), .NS_W(4)) bus ();

    swap_scheduler #(.WIDTH(4), .GAP_W(4), .NS_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // down_val pattern: value present during cycle c
    function automatic int fdown(input int c);
        return (c * 5 + 3) % 16;
    endfunction

    always @(negedge clock) bus.down_val = 4'(fdown(cyc));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        ev_t e;
        if (bus.swap === 1'b1) begin
            if (swap_q.size() == 0) begin
                check("swap_unexpected", int'(bus.swap), 0);
            end else begin
                e = swap_q.pop_front();
                check("swap_cycle", cyc, e.at);
                check("swap_count_before", int'(bus.swaps_done), e.sd);
                check("swap_enable", int'(bus.enable), 1);
                check("swap_busy", int'(bus.busy), 1);
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", int'(bus.done), 0);
            end else begin
                e = done_q.pop_front();
                check("done_cycle", cyc, e.at);
                check("done_swaps_done", int'(bus.swaps_done), e.sd);
                check("done_last_down", int'(bus.last_down), e.ld);
                check("done_busy", int'(bus.busy), 0);
                check("done_enable", int'(bus.enable), 0);
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (swap_q.size() == 0 && done_q.size() == 0) return;
            @(negedge clock);
        end
        check("drain_timeout", swap_q.size() + done_q.size(), 0);
        swap_q.delete();
        done_q.delete();
    endtask

    task automatic check_quiet(input string name, input int sd, input int ld);
        check({name, "_enable"}, int'(bus.enable), 0);
        check({name, "_swap"}, int'(bus.swap), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_done"}, int'(bus.done), 0);
        check({name, "_swaps_done"}, int'(bus.swaps_done), sd);
        check({name, "_last_down"}, int'(bus.last_down), ld);
    endtask

    // Plain run without threshold: swap i lands in cycle i*(p+2), done one cycle after the last.
    task automatic run(input int p, input int n, input int zero_ld, input bit poke);
        int b;
        int last;
        bus.period    = 4'(p);
        bus.n_swaps   = 4'(n);
        bus.thresh_en = 1'b0;
        bus.start     = 1'b1;
        b = cyc;
        for (int i = 1; i <= n; i++) swap_q.push_back('{at: b + i * (p + 2), sd: i - 1, ld: 0});
        last = b + n * (p + 2);
        done_q.push_back('{at: last + 1, sd: n, ld: (n == 0) ? zero_ld : fdown(last)});
        @(negedge clock);
        bus.start = 1'b0;
        if (poke) begin
            @(negedge clock);
            bus.start   = 1'b1;
            bus.n_swaps = 4'd1;
            bus.period  = 4'd0;
            @(negedge clock);
            bus.start = 1'b0;
        end
        drain();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int b;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.period    = '0;
        bus.n_swaps   = '0;
        bus.thresh_en = 1'b0;
        bus.thresh    = '0;
        bus.up_val    = '0;

        repeat (2) @(negedge clock);
        check_quiet("reset", 0, 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check_quiet("idle", 0, 0);
        end

        // zero swaps: done next cycle, no exchange
        run(0, 0, 0, 1'b0);

        // period=2, n=3, with a start poke during COUNT that must be ignored
        run(2, 3, 0, 1'b1);
        check_quiet("after_run", 3, fdown(cyc - 4));

        // early threshold on the 2nd COUNT cycle
        bus.period    = 4'd15;
        bus.n_swaps   = 4'd1;
        bus.thresh_en = 1'b1;
        bus.thresh    = 4'd5;
        bus.up_val    = 4'd0;
        bus.start     = 1'b1;
        b = cyc;
        swap_q.push_back('{at: b + 3, sd: 0, ld: 0});
        done_q.push_back('{at: b + 4, sd: 1, ld: fdown(b + 3)});
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.up_val = 4'd5;
        @(negedge clock);
        bus.up_val    = 4'd0;
        bus.thresh_en = 1'b0;
        drain();
        repeat (2) @(negedge clock);

        // abort in the 2nd COUNT phase of period=3, n=4
        bus.period  = 4'd3;
        bus.n_swaps = 4'd4;
        bus.start   = 1'b1;
        b = cyc;
        swap_q.push_back('{at: b + 5, sd: 0, ld: 0});
        @(negedge clock);
        bus.start = 1'b0;
        repeat (6) @(negedge clock);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        check_quiet("abort", 1, fdown(b + 5));
        repeat (8) @(negedge clock);
        check("abort_pending", swap_q.size() + done_q.size(), 0);
        swap_q.delete();
        done_q.delete();

        // reset asserted during a SWAP cycle
        bus.period  = 4'd1;
        bus.n_swaps = 4'd3;
        bus.start   = 1'b1;
        b = cyc;
        swap_q.push_back('{at: b + 3, sd: 0, ld: 0});
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_reset_swap", int'(bus.swap), 1);
        reset = 1'b1;
        @(negedge clock);
        check_quiet("reset_in_swap", 0, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_quiet("post_reset_idle", 0, 0);
        check("reset_pending", swap_q.size() + done_q.size(), 0);
        swap_q.delete();
        done_q.delete();

        // period=0, n=2: swaps in cycles 2 and 4, done in 5
        run(0, 2, 0, 1'b0);

        check("final_queues", swap_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
